led_disp_mux: RTL and testbench
===============================

LED_DISP_MUX -- requirements
Module: led_disp_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed hex digits; legal range 1..8.
REQ-002 Parameter DIV, default 50000, clock cycles per digit slot; legal range 2..2^20.
REQ-003 Parameter BLANK, default 4, anti-ghost blank cycles at start of each slot; legal range 0..DIV-1.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 en  input  1  scan enable; 0 blanks display.
REQ-007 load  input  1  single-cycle strobe capturing data/dp into pending buffer.
REQ-008 data  input  4*NUM_DIGITS  hex nibbles; digit k = data[4k+3:4k], digit 0 rightmost.
REQ-009 dp  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
REQ-010 seg  output  7  segments a..g, seg[6]=a, active-low.
REQ-011 dp_n  output  1  decimal point segment, active-low.
REQ-012 an  output  NUM_DIGITS  digit anodes, active-low one-hot, an[k] = digit k.
REQ-013 frame  output  1  one-cycle pulse marking start of a new scan frame.

Function
REQ-014 Prescaler cnt SHALL count 0..DIV-1 while en=1 and wrap to 0; idx SHALL advance when cnt=DIV-1, wrapping NUM_DIGITS-1 -> 0.
REQ-015 load=1 SHALL copy data/dp into pending buffer at that edge; repeated loads within a frame: last wins.
REQ-016 Shadow (displayed) buffer SHALL update only at frame wrap (cnt=DIV-1, idx=NUM_DIGITS-1): from data/dp if load=1 that cycle, else from pending; no mid-frame tearing.
REQ-017 frame SHALL be 1 in the cycle following a frame wrap, 0 otherwise.
REQ-018 All outputs SHALL be registered; outputs reflect the cnt/idx/shadow values of the previous cycle (latency 1).
REQ-019 When previous-cycle cnt < BLANK: an all 1, seg 7'b1111111, dp_n 1.
REQ-020 Otherwise an = all 1 except an[idx]=0; seg = decode(shadow nibble idx); dp_n = ~shadow_dp[idx].
REQ-021 Decode (abcdefg): 0 0000001, 1 1001111, 2 0010010, 3 0000110, 4 1001100, 5 0100100, 6 0100000, 7 0001101, 8 0000000, 9 0000100, A 0001000, B 1100000, C 0110001, D 1000010, E 0110000, F 0111000.
REQ-022 en=0 SHALL force cnt=0, idx=0, an all 1, seg all 1, dp_n 1, frame 0 from the next edge; pending capture via load still works; shadow holds.
REQ-023 en 0->1 SHALL restart scanning at idx 0, cnt 0; no frame pulse until the first wrap.

Reset
REQ-024 rst_n=0 SHALL immediately clear cnt, idx, pending, shadow, frame to 0 and set an all 1, seg 7'b1111111, dp_n 1.
REQ-025 Reset mid-frame SHALL discard pending data; after release with en=1 display shows 0 on all digits once blank period passes.

Configuration
REQ-026 Macro LED_DISP_LZB_EN defined: leading-zero blanking; digit k>0 whose nibble and all higher nibbles are 0 SHALL output seg 7'b1111111 (an still scans, dp_n still per dp); digit 0 never blanked.
REQ-027 Macro undefined: every digit decoded per REQ-021; no blanking logic synthesised.

Verification (NUM_DIGITS=4, DIV=8, BLANK=2)
REQ-028 Reset asserted mid-scan -> same cycle an=4'b1111, seg=7'b1111111, dp_n=1, frame=0; after release idx 0 slot shows seg=7'b0000001 at cnt>=2.
REQ-029 load data=16'h12AF dp=4'b0001, wait frame -> digit0 slot an=4'b1110 seg=7'b0111000 dp_n=0; digit1 an=4'b1101 seg=7'b0001000; digit3 seg=7'b1001111.
REQ-030 load 16'h3333 during idx=1 slot -> displayed digits unchanged until next frame pulse, then all slots seg=7'b0000110.
REQ-031 load 16'h8888 in exact wrap cycle -> frame pulse next cycle and following frame shows 7'b0000000; pending not used.
REQ-032 en deasserted at idx=2 cnt=5 -> next cycle an=4'b1111, seg all 1; reasserted -> scan restarts at an=4'b1110 after 2 blank cycles.
REQ-033 LED_DISP_LZB_EN defined, data=16'h0050 -> digits 3,2 seg=7'b1111111, digit1 7'b0100100, digit0 7'b0000001; macro undefined -> digits 3,2 show 7'b0000001.

Source files
------------

// File: rtl/led_disp_mux_if.sv
// Bus bundle for the multiplexed hex LED display driver: scan control and
// buffer load inputs from the host, segment/anode drive outputs to the panel.
interface led_disp_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      en;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   data;
    logic [NUM_DIGITS-1:0]     dp;
    logic [6:0]                seg;
    logic                      dp_n;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame;

    modport master (
        output en, load, data, dp,
        input  seg, dp_n, an, frame
    );

    modport slave (
        input  en, load, data, dp,
        output seg, dp_n, an, frame
    );
endinterface

// File: rtl/led_disp_mux.sv
// Time-multiplexed hex LED display driver with double-buffered digit data.
// Optional leading-zero blanking is compiled in when LED_DISP_LZB_EN is defined.
module led_disp_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 50000,
    parameter int BLANK      = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    led_disp_mux_if.slave   bus
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    // Hex nibble to active-low abcdefg pattern, seg[6] = a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001101;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            4'hF:    s = 7'b0111000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [CW-1:0]         cnt_r;
    logic [IW-1:0]         idx_r;
    logic [DW-1:0]         pend_data_r;
    logic [NUM_DIGITS-1:0] pend_dp_r;
    logic [DW-1:0]         shad_data_r;
    logic [NUM_DIGITS-1:0] shad_dp_r;

    logic [6:0]            seg_r;
    logic                  dp_n_r;
    logic [NUM_DIGITS-1:0] an_r;
    logic                  frame_r;

    logic                  slot_end_s;
    logic                  wrap_s;
    logic                  blank_s;
    logic [3:0]            sel_nib_s;
    logic                  sel_dp_s;
    logic [NUM_DIGITS-1:0] an_dec_s;
    logic [6:0]            seg_next_s;

    assign slot_end_s = (cnt_r == CNT_LAST);
    assign wrap_s     = bus.en & slot_end_s & (idx_r == IDX_LAST);
    assign blank_s    = (32'(cnt_r) < 32'(BLANK));

    // Select the current slot's nibble, decimal point and anode pattern.
    always_comb begin
        sel_nib_s = 4'h0;
        sel_dp_s  = 1'b0;
        an_dec_s  = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            sel_nib_s   = sel_nib_s | ((32'(idx_r) == 32'(k)) ? shad_data_r[4*k +: 4] : 4'h0);
            sel_dp_s    = sel_dp_s | ((32'(idx_r) == 32'(k)) & shad_dp_r[k]);
            an_dec_s[k] = ~(32'(idx_r) == 32'(k));
        end
    end

`ifdef LED_DISP_LZB_EN
    localparam logic [NUM_DIGITS-1:0] NZ_MASK = ~(NUM_DIGITS'(1));

    logic [NUM_DIGITS-1:0] lz_s;
    logic                  sel_lz_s;

    // lz_s[k] is set when nibble k and every more significant nibble are zero.
    always_comb begin
        lz_s               = '0;
        lz_s[NUM_DIGITS-1] = (shad_data_r[DW-1 -: 4] == 4'h0);
        for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
            lz_s[k] = lz_s[k+1] & (shad_data_r[4*k +: 4] == 4'h0);
        end
    end

    // Digit 0 is masked out so a value of zero still shows a single '0'.
    assign sel_lz_s   = |(lz_s & ~an_dec_s & NZ_MASK);
    assign seg_next_s = sel_lz_s ? 7'b1111111 : hex_to_seg(sel_nib_s);
`else
    assign seg_next_s = hex_to_seg(sel_nib_s);
`endif

    // Slot prescaler and digit index; disabling scan parks both at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
            idx_r <= '0;
        end else if (!bus.en) begin
            cnt_r <= '0;
            idx_r <= '0;
        end else if (slot_end_s) begin
            cnt_r <= '0;
            idx_r <= (idx_r == IDX_LAST) ? '0 : idx_r + IW'(1);
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // Pending buffer takes every load; shadow only moves at frame wrap so a
    // frame is never drawn from two different data sets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_data_r <= '0;
            pend_dp_r   <= '0;
            shad_data_r <= '0;
            shad_dp_r   <= '0;
        end else begin
            if (bus.load) begin
                pend_data_r <= bus.data;
                pend_dp_r   <= bus.dp;
            end else begin
                pend_data_r <= pend_data_r;
                pend_dp_r   <= pend_dp_r;
            end
            if (wrap_s) begin
                shad_data_r <= bus.load ? bus.data : pend_data_r;
                shad_dp_r   <= bus.load ? bus.dp   : pend_dp_r;
            end else begin
                shad_data_r <= shad_data_r;
                shad_dp_r   <= shad_dp_r;
            end
        end
    end

    // Registered panel drive; blank window at slot start suppresses ghosting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_r    <= '1;
            seg_r   <= 7'b1111111;
            dp_n_r  <= 1'b1;
            frame_r <= 1'b0;
        end else begin
            frame_r <= wrap_s;
            if (!bus.en || blank_s) begin
                an_r   <= '1;
                seg_r  <= 7'b1111111;
                dp_n_r <= 1'b1;
            end else begin
                an_r   <= an_dec_s;
                seg_r  <= seg_next_s;
                dp_n_r <= ~sel_dp_s;
            end
        end
    end

    assign bus.an    = an_r;
    assign bus.seg   = seg_r;
    assign bus.dp_n  = dp_n_r;
    assign bus.frame = frame_r;

endmodule

// File: tb/tb_led_disp_mux.sv
// Randomized self-checking bench for led_disp_mux against a position-based
// reference model of the scan (slot = position / DIV, offset = position % DIV).
module tb_led_disp_mux;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = DIV * N;

    logic clk;
    logic rst_n;

    led_disp_mux_if #(.NUM_DIGITS(N)) bus ();

    led_disp_mux #(.NUM_DIGITS(N), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    int n_checks;
    int n_fails;

    // Model state: scan position within the frame plus both buffers.
    int         pos;
    logic [15:0] pd, sd;
    logic [3:0]  pp, sp;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dpn;
    logic        e_frame;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        pos = 0; pd = 16'h0; sd = 16'h0; pp = 4'h0; sp = 4'h0;
        e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1; e_frame = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        int slot, off;
        logic wrap;
        logic [15:0] sh;
        logic [3:0] nib;
        slot = (pos / DIV) % N;
        off  = pos % DIV;
        wrap = bus.en && (off == DIV - 1) && (slot == N - 1);
        e_frame = wrap;
        if (!bus.en || off < BLANK) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1;
        end else begin
            sh    = sd >> (4 * slot);
            nib   = sh[3:0];
            e_an  = 4'hF & ~(4'h1 << slot);
            e_seg = seg_tab[nib];
            e_dpn = ~sp[slot];
`ifdef LED_DISP_LZB_EN
            if (slot > 0 && sh == 16'h0) e_seg = 7'h7F;
`endif
        end
        if (wrap) begin
            sd = bus.load ? bus.data : pd;
            sp = bus.load ? bus.dp   : pp;
        end
        if (bus.load) begin
            pd = bus.data;
            pp = bus.dp;
        end
        pos = bus.en ? (pos + 1) % FRAME : 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_eq("an",    32'(bus.an),    32'(e_an));
        check_eq("seg",   32'(bus.seg),   32'(e_seg));
        check_eq("dp_n",  32'(bus.dp_n),  32'(e_dpn));
        check_eq("frame", 32'(bus.frame), 32'(e_frame));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_an"},    32'(bus.an),    32'h0000000F);
        check_eq({tag, "_seg"},   32'(bus.seg),   32'h0000007F);
        check_eq({tag, "_dp_n"},  32'(bus.dp_n),  32'h00000001);
        check_eq({tag, "_frame"}, 32'(bus.frame), 32'h00000000);
    endtask

    initial begin
        bit seen;
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.load = 1'b0;
        bus.data = 16'h0;
        bus.dp   = 4'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n  = 1'b1;
        bus.en = 1'b1;

        // Load 12AF with dp on digit 0, then wait for it to become visible.
        bus.load = 1'b1; bus.data = 16'h12AF; bus.dp = 4'b0001;
        tick();
        bus.load = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3 * FRAME && !seen; i++) begin
            tick();
            seen = bus.frame;
        end
        check_eq("frame_seen", 32'(seen), 32'h1);
        repeat (3) tick();
        check_eq("d0_an",   32'(bus.an),   32'h0000000E);
        check_eq("d0_seg",  32'(bus.seg),  32'(7'b0111000));
        check_eq("d0_dp_n", 32'(bus.dp_n), 32'h0);
        repeat (DIV) tick();
        check_eq("d1_an",   32'(bus.an),   32'h0000000D);
        check_eq("d1_seg",  32'(bus.seg),  32'(7'b0001000));

        // Load 8888 exactly in the wrap cycle; pending (3333) must be bypassed.
        bus.load = 1'b1; bus.data = 16'h3333; bus.dp = 4'h0;
        tick();
        bus.load = 1'b0;
        for (int i = 0; i < 2 * FRAME && pos != FRAME - 1; i++) tick();
        bus.load = 1'b1; bus.data = 16'h8888; bus.dp = 4'h0;
        tick();
        bus.load = 1'b0;
        check_eq("wrap_frame", 32'(bus.frame), 32'h1);
        repeat (BLANK + 1) tick();
        check_eq("wrap_seg", 32'(bus.seg), 32'(7'b0000000));

        // Randomized traffic with enable bursts, loads and mid-scan resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) bus.en = ~bus.en;
            bus.load = ($urandom_range(0, 15) == 0);
            bus.data = 16'($urandom);
            bus.dp   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                #1 check_reset_outputs("async_reset");
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
